mitchell_antilog: RTL

//  Pipelined log2-domain -> linear converter (Mitchell antilog); inverse of the leading-one/log path.

---
 rtl/attn_pkg.sv | 15 +
 rtl/log_shl.sv | 25 ++
 rtl/mitchell_antilog.sv | 97 +++++++++
 3 files changed

// File: rtl/attn_pkg.sv
// Shared definitions for the attention-head log-domain datapath.
package attn_pkg;

    localparam int D_W_DEF = 32;
    localparam int F_W_DEF = 8;
    localparam int E_W     = $clog2(D_W_DEF);

    // Fixed-point log2 value: integer exponent plus fraction below the implicit one.
    typedef struct packed {
        logic                 zero;
        logic [E_W-1:0]       exp;
        logic [F_W_DEF-1:0]   frac;
    } log_t;

endpackage

// File: rtl/log_shl.sv
// Combinational left barrel shifter: (F_W+1)-bit mantissa shifted by 0..2^SH_W-1
// into a D_W+F_W wide product, built as log2(D_W) conditional-shift stages.
module log_shl #(
    parameter int D_W  = 32,
    parameter int F_W  = 8,
    parameter int SH_W = $clog2(D_W)
) (
    input  logic [F_W:0]       mant,
    input  logic [SH_W-1:0]    sh,
    output logic [D_W+F_W-1:0] prod
);

    localparam int P_W = D_W + F_W;

    logic [P_W-1:0] stage [SH_W+1];

    assign stage[0] = P_W'(mant);

    for (genvar i = 0; i < SH_W; i++) begin : g_stage
        assign stage[i+1] = sh[i] ? (stage[i] << (1 << i)) : stage[i];
    end

    assign prod = stage[SH_W];

endmodule

// File: rtl/mitchell_antilog.sv
// Mitchell antilog: log2 value {k, f} -> floor(2^k * (1 + f/2^F_W)), two register
// stages with valid/ready on both sides. S1 holds the decoded input, S2 the
// truncated shifted result that drives out_data.
module mitchell_antilog
    import attn_pkg::*;
#(
    parameter int D_W   = D_W_DEF,
    parameter int F_W   = F_W_DEF,
    parameter int EXP_W = $clog2(D_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [F_W-1:0]   in_frac,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_W-1:0]   out_data
);

    logic             adv1;
    logic             adv2;

    logic             s1_valid;
    logic             s1_zero;
    logic [EXP_W-1:0] s1_exp;
    logic [F_W:0]     s1_mant;

    logic             s2_valid;
    logic [D_W-1:0]   s2_data;

    logic [D_W+F_W-1:0] prod;
    logic               oor;
    logic [D_W-1:0]     s1_result;
    logic               unused_prod_lsb;

    // A stage may load when it is empty or its contents leave this cycle.
    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    log_shl #(
        .D_W  (D_W),
        .F_W  (F_W),
        .SH_W (EXP_W)
    ) u_shl (
        .mant (s1_mant),
        .sh   (s1_exp),
        .prod (prod)
    );

    // Exponents past the output width only exist when D_W is not a power of two.
    if ((1 << EXP_W) == D_W) begin : g_pow2
        assign oor = 1'b0;
    end else begin : g_npow2
        assign oor = (32'(s1_exp) >= 32'(D_W));
    end

    // Bits below the binary point are truncated away.
    assign s1_result       = (s1_zero || oor) ? '0 : prod[D_W+F_W-1:F_W];
    assign unused_prod_lsb = ^prod[F_W-1:0];

    // Valid bits: cleared by reset so in-flight beats are discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (adv1) s1_valid <= in_valid;
            if (adv2) s2_valid <= s1_valid;
        end
    end

    // S1 data: capture the input beat with its implicit leading one; no reset needed.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_zero <= in_zero;
            s1_exp  <= in_exp;
            s1_mant <= {1'b1, in_frac};
        end
    end

    // S2 data: reset to zero so out_data is defined; only real beats are loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_data <= '0;
        end else if (adv2 && s1_valid) begin
            s2_data <= s1_result;
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;

endmodule
